reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
Parametrised successor to the MIPS core's two-read/one-write register file.
- Generic data width and depth; register 0 hard-wired to zero.
- Write-to-read bypass on both read ports.
- Per-register busy scoreboard for multi-cycle producers (loads, multiplier).
- Sequential clear engine that zeroes the whole array after reset or on request.

Sits between decode (reads), writeback (writes) and the hazard unit (busy flags, ready).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = write data forwarded to same-cycle reads of the written address; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
read_address_1  in  ADDR_W  read port 1 address
read_address_2  in  ADDR_W  read port 2 address
read_data_1  out  DATA_W  read port 1 data (combinational)
read_data_2  out  DATA_W  read port 2 data (combinational)
read_busy_1  out  1  register at read_address_1 has a pending producer
read_busy_2  out  1  register at read_address_2 has a pending producer
write_address  in  ADDR_W  write address
write_data  in  DATA_W  write data
reg_write_en  in  1  write strobe
busy_set_en  in  1  mark busy_set_address as pending
busy_set_address  in  ADDR_W  register claimed by an issued multi-cycle op
clear_req  in  1  single-cycle request to re-zero the array
ready  out  1  1 = array valid, writes and busy updates accepted

Behaviour:
- Reset (rst_n low, async): state = INIT, sweep counter = 0, all busy bits = 0, ready = 0. The array itself has no reset.
- State INIT:
  - Each edge writes 0 to array[counter] and increments the counter.
  - On the edge where counter == DEPTH-1, state goes to READY.
  - ready rises after exactly DEPTH edges following rst_n release (32 with the defaults).
  - reg_write_en, busy_set_en and clear_req are ignored. The counter is not restarted.
  - read_data_* = 0 and read_busy_* = 0 regardless of address.
- State READY:
  - ready = 1.
  - A write with reg_write_en = 1 and write_address != 0 updates the array on the edge and clears busy[write_address].
  - A write to address 0 is dropped.
  - busy_set_en = 1 and busy_set_address != 0 sets busy[busy_set_address] on the edge.
  - If a write and a busy set target the same address in the same cycle, the set wins: the data is written and busy ends at 1.
  - clear_req = 1: next edge state = INIT, counter = 0, all busy bits = 0. Any write or busy set in that cycle is dropped.
- Reads (READY, combinational, zero latency):
  - Address 0 returns 0 with busy = 0.
  - If BYPASS = 1, reg_write_en = 1 and the read address equals write_address (nonzero), read_data returns write_data and read_busy returns 0.
  - Otherwise read_data returns array[addr] and read_busy returns busy[addr].
  - Both ports are independent; reading the same address on both ports is legal.
- Widths: no arithmetic on data. The counter is ADDR_W+1 bits or compared against DEPTH-1, so there is no wrap before the transition.
- Reset mid-sweep or mid-operation: async return to INIT with counter 0. A full sweep is always required before ready = 1.

Test Plan:
1. Release rst_n; hold reg_write_en = 1, write_address = 8, write_data = 0xDEAD during the sweep -> ready = 0 for 32 edges, then 1. Reading address 8 returns 0, so the sweep-time write was dropped.
2. After ready: write 0x12345678 to address 9. Read both ports at address 9 in the same cycle -> 0x12345678 via bypass. The next cycle, with no write, also returns 0x12345678.
3. Write 0xFFFFFFFF to address 0 -> read address 0 returns 0 and read_busy = 0. With BYPASS = 0, a same-cycle read of address 10 during a write of 0xABCD returns the old value; the next cycle returns 0xABCD.
4. busy_set_en to address 16 -> read_busy = 1 at address 16. A later write of 0x55 to address 16 -> busy = 0 after the edge, and the same-cycle bypassed read shows data 0x55, busy 0. Setting and writing address 17 in the same cycle -> busy[17] = 1 and data updated.
5. With busy set on addresses 16 and 20 and data 0x55 in address 16, pulse clear_req alongside a write of 0x77 to address 18 -> ready drops for 32 edges. Afterwards addresses 16, 18 and 20 read 0 and all busy bits are 0.
6. Assert rst_n low at sweep count 10 -> ready stays 0. After release, a full 32-edge sweep occurs before ready = 1.

Source files
------------

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with register 0 tied to zero, write-to-read bypass,
// a per-register busy scoreboard, and a sequential clear engine that zeroes the array.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_address_1,
  input  logic [ADDR_W-1:0] read_address_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_1,
  output logic              read_busy_2,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write_en,
  input  logic              busy_set_en,
  input  logic [ADDR_W-1:0] busy_set_address,
  input  logic              clear_req,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit BYPASS_ON = (BYPASS != 0);
  localparam logic [ADDR_W:0] LAST_INDEX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [DEPTH-1:0]  busy_reg, busy_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              is_ready;
  logic              write_ok;
  logic              set_ok;

  assign is_ready = (state_reg == ST_READY);
  assign ready    = is_ready;
  assign write_ok = reg_write_en && (write_address != '0);
  assign set_ok   = busy_set_en && (busy_set_address != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      count_reg <= '0;
      busy_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    busy_next  = busy_reg;
    mem_we     = 1'b0;
    mem_waddr  = write_address;
    mem_wdata  = write_data;
    case (state_reg)
      ST_INIT: begin
        // Sweep one register per edge; all external requests are ignored.
        mem_we     = 1'b1;
        mem_waddr  = count_reg[ADDR_W-1:0];
        mem_wdata  = '0;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_INDEX) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_next = ST_INIT;
          count_next = '0;
          busy_next  = '0;
        end else begin
          if (write_ok) begin
            mem_we                   = 1'b1;
            busy_next[write_address] = 1'b0;
          end
          // Applied after the clear so a same-address set wins.
          if (set_ok) begin
            busy_next[busy_set_address] = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_INIT;
        count_next = '0;
        busy_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             rd_busy;

  assign rd_addr[0] = read_address_1;
  assign rd_addr[1] = read_address_2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      logic zero_out;
      logic hit;
      assign zero_out    = !is_ready || (rd_addr[gi] == '0);
      assign hit         = BYPASS_ON && reg_write_en && (rd_addr[gi] == write_address);
      assign rd_data[gi] = zero_out ? '0 : (hit ? write_data : mem[rd_addr[gi]]);
      assign rd_busy[gi] = zero_out ? 1'b0 : (hit ? 1'b0 : busy_reg[rd_addr[gi]]);
    end
  endgenerate

  assign read_data_1 = rd_data[0];
  assign read_data_2 = rd_data[1];
  assign read_busy_1 = rd_busy[0];
  assign read_busy_2 = rd_busy[1];

endmodule
